// File: rtl/nbyn_b2_seq_multiplier_pkg.sv
// rtl/nbyn_b2_seq_multiplier_pkg.sv - shared constants, state encoding and digit slicing for the sequential multiplier
package nbyn_b2_seq_multiplier_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned IDX_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit offset of digit number idx inside a packed multi-digit vector.
    function automatic int unsigned digit_lsb(input logic [IDX_W-1:0] idx);
        return 32'(idx) * DIGIT_W;
    endfunction

endpackage

// File: rtl/n4by4_b2_multiplier.sv
// rtl/n4by4_b2_multiplier.sv - combinational 4x4 digit multiplier with 4-bit addend, m = x*y + c
module n4by4_b2_multiplier (
    input  logic [3:0] x3_x0,
    input  logic [3:0] y3_y0,
    input  logic [3:0] c3_c0,
    output logic [7:0] m7_m0
);

    // 15*15 + 15 = 240 fits in 8 bits.
    assign m7_m0 = ({4'b0, x3_x0} * {4'b0, y3_y0}) + {4'b0, c3_c0};

endmodule

// File: rtl/nbyn_b2_seq_multiplier.sv
// rtl/nbyn_b2_seq_multiplier.sv - schoolbook sequential multiplier, one digit product per clock; MUL_ADDEND_EN adds c so p = x*y + c
module nbyn_b2_seq_multiplier
    import nbyn_b2_seq_multiplier_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                            clock,
    input  logic                            reset_,
    input  logic                            soc,
    input  logic [DIGIT_W*DIGITS-1:0]       x,
    input  logic [DIGIT_W*DIGITS-1:0]       y,
`ifdef MUL_ADDEND_EN
    input  logic [DIGIT_W*DIGITS-1:0]       c,
`endif
    output logic                            eoc,
    output logic [2*DIGIT_W*DIGITS-1:0]     p
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] DIG_IDX  = IDX_W'(DIGITS);

    state_t                          state_q, state_d;
    logic [DIGIT_W*DIGITS-1:0]       x_q, x_d, y_q, y_d;
    logic [2*DIGIT_W*DIGITS-1:0]     p_q, p_d;
    logic [IDX_W-1:0]                i_q, i_d, j_q, j_d;
    logic [DIGIT_W-1:0]              k_q, k_d;

    logic [DIGIT_W-1:0]              x_dig, y_dig, acc_dig;
    logic [7:0]                      m, s;
    logic [IDX_W-1:0]                ij, j_hi;

    assign ij      = i_q + j_q;
    assign j_hi    = j_q + DIG_IDX;
    assign x_dig   = x_q[digit_lsb(i_q) +: DIGIT_W];
    assign y_dig   = y_q[digit_lsb(j_q) +: DIGIT_W];
    assign acc_dig = p_q[digit_lsb(ij) +: DIGIT_W];
    assign s       = m + {4'b0, acc_dig};

    n4by4_b2_multiplier u_digit_mul (
        .x3_x0 (x_dig),
        .y3_y0 (y_dig),
        .c3_c0 (k_q),
        .m7_m0 (m)
    );

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            p_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            p_q     <= p_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        p_d     = p_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        unique case (state_q)
            S_IDLE: begin
                if (soc) begin
                    x_d     = x;
                    y_d     = y;
`ifdef MUL_ADDEND_EN
                    p_d     = {{(DIGIT_W*DIGITS){1'b0}}, c};
`else
                    p_d     = '0;
`endif
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                p_d[digit_lsb(ij) +: DIGIT_W] = s[3:0];
                k_d = s[7:4];
                if (i_q == LAST_IDX) begin
                    // Row finished: the carry becomes the next, not yet touched, digit.
                    p_d[digit_lsb(j_hi) +: DIGIT_W] = s[7:4];
                    k_d = '0;
                    i_d = '0;
                    j_d = j_q + 1'b1;
                    if (j_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!soc) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign eoc = (state_q != S_CALC);
    assign p   = p_q;

endmodule

// File: tb/tb_nbyn_b2_seq_multiplier.sv
// tb/tb_nbyn_b2_seq_multiplier.sv - randomized self-checking bench for DIGITS=2 and DIGITS=1; honours MUL_ADDEND_EN
module tb_nbyn_b2_seq_multiplier;

`ifdef MUL_ADDEND_EN
    localparam bit ADDEND = 1'b1;
`else
    localparam bit ADDEND = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_ = 1'b0;
    logic        soc = 1'b0, soc1 = 1'b0;
    logic [7:0]  x = '0, y = '0, c = '0;
    logic [3:0]  x1 = '0, y1 = '0, c1 = '0;
    logic        eoc, eoc1;
    logic [15:0] p;
    logic [7:0]  p1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    nbyn_b2_seq_multiplier #(.DIGITS(2)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .soc    (soc),
        .x      (x),
        .y      (y),
`ifdef MUL_ADDEND_EN
        .c      (c),
`endif
        .eoc    (eoc),
        .p      (p)
    );

    nbyn_b2_seq_multiplier #(.DIGITS(1)) dut1 (
        .clock  (clock),
        .reset_ (reset_),
        .soc    (soc1),
        .x      (x1),
        .y      (y1),
`ifdef MUL_ADDEND_EN
        .c      (c1),
`endif
        .eoc    (eoc1),
        .p      (p1)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint model(input longint xa, input longint ya, input longint ca);
        return xa * ya + (ADDEND ? ca : 0);
    endfunction

    task automatic op2(input logic [7:0] xa, input logic [7:0] ya, input logic [7:0] ca,
                       input bit hold_soc);
        int cyc;
        longint e;
        e = model(xa, ya, ca);
        @(negedge clock);
        soc = 1'b1; x = xa; y = ya; c = ca;
        @(negedge clock);
        if (!hold_soc) soc = 1'b0;
        check("eoc_busy", eoc, 0);
        cyc = 0;
        while (!eoc && cyc < 100) begin
            x = 8'($urandom); y = 8'($urandom); c = 8'($urandom);
            @(negedge clock);
            cyc++;
        end
        check("latency", cyc, 4);
        check("product", p, e);
    endtask

    task automatic op1(input logic [3:0] xa, input logic [3:0] ya, input logic [3:0] ca);
        int cyc;
        longint e;
        e = model(xa, ya, ca);
        @(negedge clock);
        soc1 = 1'b1; x1 = xa; y1 = ya; c1 = ca;
        @(negedge clock);
        soc1 = 1'b0;
        check("d1_eoc_busy", eoc1, 0);
        cyc = 0;
        while (!eoc1 && cyc < 100) begin
            x1 = 4'($urandom); y1 = 4'($urandom); c1 = 4'($urandom);
            @(negedge clock);
            cyc++;
        end
        check("d1_latency", cyc, 1);
        check("d1_product", p1, e);
    endtask

    initial begin
        logic [15:0] held;
        repeat (3) @(negedge clock);
        check("rst_eoc", eoc, 1);
        check("rst_p", p, 0);
        check("rst_eoc1", eoc1, 1);
        check("rst_p1", p1, 0);
        reset_ = 1'b1;

        op2(8'h12, 8'h34, 8'h00, 1'b0);
        check("dir_12x34", p, 16'h03A8 + (ADDEND ? 0 : 0));
        op2(8'hFF, 8'hFF, 8'h00, 1'b0);
        op2(8'hFF, 8'hFF, 8'hFF, 1'b0);
        op2(8'h00, 8'h00, 8'h00, 1'b0);
        op2(8'h00, 8'hA5, 8'h3C, 1'b0);

        // soc held through completion must not restart
        op2(8'h9C, 8'h47, 8'h11, 1'b1);
        held = p;
        x = 8'h55; y = 8'hAA; c = 8'h33;
        repeat (3) @(negedge clock);
        check("hold_eoc", eoc, 1);
        check("hold_p", p, model(8'h9C, 8'h47, 8'h11));
        soc = 1'b0;
        @(negedge clock);
        check("idle_p_kept", p, held);
        op2(8'h55, 8'hAA, 8'h33, 1'b0);

        // asynchronous reset during the second calculation cycle
        @(negedge clock);
        soc = 1'b1; x = 8'hEE; y = 8'hDD;
        @(negedge clock);
        soc = 1'b0;
        @(negedge clock);
        #1 reset_ = 1'b0;
        #1;
        check("midrst_eoc", eoc, 1);
        check("midrst_p", p, 0);
        @(negedge clock);
        reset_ = 1'b1;
        op2(8'h0F, 8'h10, 8'h00, 1'b0);
        check("after_rst", p, 16'h00F0);

        for (int n = 0; n < 20; n++) begin
            op2(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        end

        op1(4'hF, 4'hF, 4'h0);
        check("d1_FxF", p1, ADDEND ? 8'hE1 : 8'hE1);
        op1(4'hF, 4'hF, 4'hF);
        op1(4'h0, 4'h0, 4'h0);
        for (int n = 0; n < 10; n++) begin
            op1(4'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
